// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and the flat-to-matrix byte index used by
// the matrix loader and its unflatten stage.
package matrix_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_NROWS = 4;
  localparam int DEF_NCOLS = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } ld_state_e;

  // Column-major: flat byte 0 (MSB end) lands on [NROWS-1][NCOLS-1].
  function automatic int flat_idx(input int r, input int c, input int nrows);
    return (c * nrows + r) * BYTE_W;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Beat-in / block-out handshake bundle for matrix_loader; slave is the loader,
// master is whoever drives beats and consumes blocks.
interface matrix_loader_if #(
  parameter int NROWS = matrix_pkg::DEF_NROWS,
  parameter int NCOLS = matrix_pkg::DEF_NCOLS,
  parameter int IN_W  = 32
);
  localparam int TOTAL = matrix_pkg::BYTE_W * NROWS * NCOLS;

  logic                                               flush;
  logic                                               in_valid;
  logic                                               in_ready;
  logic [IN_W-1:0]                                    in_data;
  logic                                               out_valid;
  logic                                               out_ready;
  logic [NROWS-1:0][NCOLS-1:0][matrix_pkg::BYTE_W-1:0] out_matrix;
  logic [TOTAL-1:0]                                   out_flat;
  logic                                               busy;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_matrix, out_flat, busy
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_matrix, out_flat, busy
  );

endinterface

// File: rtl/state_unflatten.sv
// Pure wiring: reorders the flat block into the [row][col] byte matrix.
module state_unflatten import matrix_pkg::*; #(
  parameter int NROWS = DEF_NROWS,
  parameter int NCOLS = DEF_NCOLS
) (
  input  logic [BYTE_W*NROWS*NCOLS-1:0]          flat,
  output logic [NROWS-1:0][NCOLS-1:0][BYTE_W-1:0] matrix
);

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    for (genvar c = 0; c < NCOLS; c++) begin : g_col
      assign matrix[r][c] = flat[flat_idx(r, c, NROWS) +: BYTE_W];
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Assembles IN_W-bit beats (first beat = MSBs) into an NROWSxNCOLS byte block.
// Define MATRIX_LOADER_DBUF_EN for a second buffer that keeps input flowing
// while a block waits at the output.
module matrix_loader import matrix_pkg::*; #(
  parameter int NROWS = DEF_NROWS,
  parameter int NCOLS = DEF_NCOLS,
  parameter int IN_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  matrix_loader_if.slave  bus
);

  localparam int TOTAL = BYTE_W * NROWS * NCOLS;
  localparam int NB    = (IN_W > 0) ? TOTAL / IN_W : 1;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  if (IN_W <= 0 || (IN_W % BYTE_W) != 0 || (TOTAL % IN_W) != 0) begin : g_bad_in_w
    $error("matrix_loader: IN_W must be a multiple of 8 that divides 8*NROWS*NCOLS");
  end

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOTAL-1:0] fill_q, fill_d;
  logic [TOTAL-1:0] out_flat_q, out_flat_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef MATRIX_LOADER_DBUF_EN
  logic [TOTAL-1:0] pend_q, pend_d;
`endif

  logic             in_ready;
  logic             accept;
  logic             complete;
  logic             out_xfer;
  logic [TOTAL-1:0] blk;

  always_comb begin
    // HOLD means "no room for another block": output busy in single-buffer
    // mode, pending slot occupied in double-buffer mode.
    in_ready = (state_q == FILL) && !bus.flush;
    accept   = bus.in_valid && in_ready;
    complete = accept && (cnt_q == LAST);
    out_xfer = out_valid_q && bus.out_ready;

    blk = fill_q;
    for (int b = 0; b < NB; b++) begin
      if (cnt_q == CNT_W'(b)) blk[TOTAL-1-b*IN_W -: IN_W] = bus.in_data;
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    out_flat_d  = out_flat_q;
    out_valid_d = out_valid_q;
`ifdef MATRIX_LOADER_DBUF_EN
    pend_d      = pend_q;
`endif

    if (bus.flush) begin
      cnt_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      if (complete) begin
        cnt_d  = '0;
        fill_d = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        fill_d = blk;
      end
    end

`ifdef MATRIX_LOADER_DBUF_EN
    if (complete) begin
      // Present immediately when the output slot is free or freeing this cycle.
      if (!out_valid_q || out_xfer) begin
        out_flat_d  = blk;
        out_valid_d = 1'b1;
      end else begin
        pend_d  = blk;
        state_d = HOLD;
      end
    end else if (out_xfer) begin
      if (state_q == HOLD) begin
        out_flat_d = pend_q;
        pend_d     = '0;
        state_d    = FILL;
      end else begin
        out_valid_d = 1'b0;
      end
    end
`else
    case (state_q)
      FILL: if (complete) begin
        out_flat_d  = blk;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (out_xfer) begin
        out_valid_d = 1'b0;
        state_d     = FILL;
      end
      default: state_d = FILL;
    endcase
`endif

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      fill_q      <= '0;
      out_flat_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MATRIX_LOADER_DBUF_EN
      pend_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      out_flat_q  <= out_flat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MATRIX_LOADER_DBUF_EN
      pend_q      <= pend_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flat  = out_flat_q;
  assign bus.busy      = busy_q;

  state_unflatten #(.NROWS(NROWS), .NCOLS(NCOLS)) u_unflatten (
    .flat   (out_flat_q),
    .matrix (bus.out_matrix)
  );

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter NROWS, default 4: matrix rows (bytes per column).
REQ-002 Parameter NCOLS, default 4: matrix columns.
REQ-003 Parameter IN_W, default 32: input beat width in bits. It SHALL be a multiple of 8 and SHALL divide TOTAL = 8*NROWS*NCOLS; any other value SHALL be an elaboration error.
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discards any partially assembled block.
REQ-007 in_valid  in  1  in_data carries a beat.
REQ-008 in_ready  out  1  loader accepts a beat this cycle.
REQ-009 in_data  in  IN_W  beat; the first beat of a block is the most significant part of the block.
REQ-010 out_valid  out  1  out_matrix holds a complete block.
REQ-011 out_ready  in  1  consumer accepts out_matrix this cycle.
REQ-012 out_matrix  out  8 x [NROWS-1:0][NCOLS-1:0]  assembled state, indexed [row][col].
REQ-013 out_flat  out  TOTAL  the same block as a flat vector, first beat in the MSBs.
REQ-014 busy  out  1  high while one or more beats of an incomplete block are held.

Function
REQ-015 A beat SHALL transfer on a posedge where in_valid and in_ready are both high; an output block SHALL transfer on a posedge where out_valid and out_ready are both high.
REQ-016 Byte mapping: out_matrix[r][c] SHALL equal out_flat[(c*NROWS+r)*8 +: 8]. This is column-major: flat byte 0 (MSB) maps to [NROWS-1][NCOLS-1], and flat byte 1 maps to [NROWS-2][NCOLS-1].
REQ-017 A beat counter SHALL count 0..TOTAL/IN_W-1 and SHALL wrap to 0 on the accepted beat that completes a block.
REQ-018 out_valid SHALL rise on the posedge after the completing beat is accepted (latency 1 cycle); with IN_W == TOTAL, every accepted beat is a complete block.
REQ-019 While out_valid is high and out_ready is low, out_valid, out_matrix and out_flat SHALL hold stable.
REQ-020 Default (single buffer) state machine:
- States FILL and HOLD.
- FILL goes to HOLD on the completing beat.
- HOLD goes to FILL on the output transfer.
- in_ready SHALL be 1 in FILL and 0 in HOLD; after an output transfer, in_ready SHALL rise on the next cycle.
REQ-021 flush high SHALL force in_ready low for that cycle, clear the beat counter and the fill register, and clear busy on the next cycle. flush SHALL NOT affect a block already presented with out_valid high.
REQ-022 flush and in_valid in the same cycle: flush wins and no beat is accepted.
REQ-023 busy SHALL be high exactly when the beat counter is non-zero.
REQ-024 out_flat and out_matrix SHALL change only on the cycle out_valid rises.

Reset
REQ-025 While reset is high at a posedge, the next state SHALL be:
- state FILL, beat counter 0;
- out_valid 0, busy 0, in_ready 1;
- out_matrix and out_flat all zero;
- fill buffer (and pending buffer, if present) zero.
REQ-026 Reset asserted mid-block or while HOLD is active SHALL discard all held data without producing an output transfer.

Configuration
REQ-027 Macro MATRIX_LOADER_DBUF_EN.
- Defined: a second (fill) buffer decouples input from output.
  - in_ready SHALL stay 1 while a block is held at the output, until the fill buffer completes.
  - If the fill buffer completes while out_valid && !out_ready, that block SHALL be held as pending and in_ready SHALL be 0.
  - The pending block SHALL move to the output on the posedge of the output transfer; out_valid then stays high, and in_ready rises on the next cycle.
  - If the fill buffer completes in the same cycle as an output transfer, the new block SHALL be presented with no gap cycle.
  - flush SHALL NOT discard a pending block.
- Undefined: single-buffer behaviour per REQ-020.

Structure
REQ-028 Package matrix_pkg SHALL hold BYTE_W = 8, the default NROWS/NCOLS, and the flat-to-matrix index function of REQ-016.
REQ-029 Combinational sub-module state_unflatten SHALL perform the REQ-016 mapping from out_flat to out_matrix; all sequencing SHALL reside in matrix_loader.

Verification
REQ-030 Default parameters; beats 32'h121b1904, 32'h637a1279, 32'h74620d15, 32'h77056458 -> out_valid one cycle after the 4th beat, with [3][3]=12, [2][2]=7a, [1][3]=19, [1][1]=0d, [2][0]=05, [0][0]=58.
REQ-031 IN_W=128, same vector as a single beat -> identical matrix 1 cycle later; then hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 (undefined DBUF).
REQ-032 Two beats, then flush -> busy=0 next cycle; four further beats of 32'hffffffff -> all 16 bytes ff, with no data from the flushed beats.
REQ-033 Reset asserted after 3 beats and again during HOLD -> out_valid=0 and out_flat=0 next cycle; no output transfer occurs.
REQ-034 DBUF_EN defined, out_ready=0, 8 back-to-back beats -> second block pending and in_ready=0; out_ready=1 -> first block transfers, then second block valid the next cycle.
REQ-035 NROWS=2, NCOLS=8, IN_W=16; flat bytes 00..0f streamed MSB-first -> [1][7]=00, [0][7]=01, [0][0]=0f.
